// File: rtl/param_alu_pkg.sv
// param_alu_pkg: shared opcode and FSM state types for the parameterised ALU.
package param_alu_pkg;

   localparam int unsigned OPCODE_W = 2;

   typedef enum logic [OPCODE_W-1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_ACC = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OPB  = 2'b01,
      EXEC = 2'b10,
      DONE = 2'b11
   } state_e;

endpackage

// File: rtl/param_alu_core.sv
// param_alu_core: combinational arithmetic for param_alu.
// Produces the raw (optionally saturated) result and overflow flag for one
// opcode. The ACC opcode adds like ADD only when PARAM_ALU_ACC_EN is defined;
// otherwise it yields zero result and no overflow.
module param_alu_core
   import param_alu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned SATURATE   = 0
) (
   input  op_e                   op_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic [DATA_WIDTH-1:0] res_o,
   output logic                  ov_o
);

   localparam int unsigned W = DATA_WIDTH;

   logic [W:0]     sum;
   logic [W:0]     diff;
   logic [2*W-1:0] prod;

   // Evaluate all three arithmetic forms, then select and clamp by opcode
   always_comb begin
      sum   = {1'b0, a_i} + {1'b0, b_i};
      diff  = {1'b0, a_i} - {1'b0, b_i};
      prod  = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};
      res_o = '0;
      ov_o  = 1'b0;
      case (op_i)
         OP_ADD: begin
            res_o = sum[W-1:0];
            ov_o  = sum[W];
            if ((SATURATE != 0) && sum[W]) res_o = '1;
         end
         OP_SUB: begin
            // the extra MSB of the widened difference is the borrow (A < B)
            res_o = diff[W-1:0];
            ov_o  = diff[W];
            if ((SATURATE != 0) && diff[W]) res_o = '0;
         end
         OP_MUL: begin
            res_o = prod[W-1:0];
            ov_o  = |prod[2*W-1:W];
            if ((SATURATE != 0) && ov_o) res_o = '1;
         end
         OP_ACC: begin
`ifdef PARAM_ALU_ACC_EN
            res_o = sum[W-1:0];
            ov_o  = sum[W];
            if ((SATURATE != 0) && sum[W]) res_o = '1;
`else
            res_o = '0;
            ov_o  = 1'b0;
`endif
         end
         default: begin
            res_o = '0;
            ov_o  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/param_alu.sv
// param_alu: two-operand (ADD/SUB/MUL) and single-operand (ACC) ALU with a
// command FSM IDLE -> OPB -> EXEC -> DONE. ACC skips OPB.
// Optional feature macro: PARAM_ALU_ACC_EN adds the accumulator register and
// makes ACC compute acc + A; without it ACC returns zero.
// DATA_WIDTH legal range 4..32.
module param_alu
   import param_alu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned SATURATE   = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  opcode_valid,
   input  logic [1:0]            opcode,
   input  logic [DATA_WIDTH-1:0] data,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  overflow,
   output logic                  busy
);

   state_e                state_q;
   op_e                   op_q;
   logic [DATA_WIDTH-1:0] a_q;
   logic [DATA_WIDTH-1:0] b_q;
   logic [DATA_WIDTH-1:0] result_q;
   logic                  overflow_q;
   logic                  done_q;
   logic                  busy_q;

   logic [DATA_WIDTH-1:0] opb_d;
   logic [DATA_WIDTH-1:0] res_d;
   logic                  ov_d;

`ifdef PARAM_ALU_ACC_EN
   logic [DATA_WIDTH-1:0] acc_q;

   // ACC takes its second operand from the accumulator instead of B
   always_comb opb_d = (op_q == OP_ACC) ? acc_q : b_q;
`else
   // Second operand is always the latched B
   always_comb opb_d = b_q;
`endif

   param_alu_core #(
      .DATA_WIDTH (DATA_WIDTH),
      .SATURATE   (SATURATE)
   ) u_core (
      .op_i  (op_q),
      .a_i   (a_q),
      .b_i   (opb_d),
      .res_o (res_d),
      .ov_o  (ov_d)
   );

   // Command FSM with operand latches and registered outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         op_q       <= OP_ADD;
         a_q        <= '0;
         b_q        <= '0;
         result_q   <= '0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
`ifdef PARAM_ALU_ACC_EN
         acc_q      <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (opcode_valid) begin
                  op_q   <= op_e'(opcode);
                  a_q    <= data;
                  busy_q <= 1'b1;
                  state_q <= (op_e'(opcode) == OP_ACC) ? EXEC : OPB;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            OPB: begin
               b_q     <= data;
               busy_q  <= 1'b1;
               state_q <= EXEC;
            end
            EXEC: begin
               result_q   <= res_d;
               overflow_q <= ov_d;
               done_q     <= 1'b1;
               busy_q     <= 1'b0;
               state_q    <= DONE;
`ifdef PARAM_ALU_ACC_EN
               if (op_q == OP_ACC) acc_q <= res_d;
`endif
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign done     = done_q;
   assign result   = result_q;
   assign overflow = overflow_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_param_alu.sv
// tb_param_alu: directed bench for param_alu (DATA_WIDTH=8), two instances
// with SATURATE=0 and SATURATE=1 sharing stimulus. Expected outputs come from
// a per-cycle timeline filled in by the stimulus tasks using plain arithmetic.
module tb_param_alu;

   localparam int MAXC = 256;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       opcode_valid;
   logic [1:0] opcode;
   logic [7:0] data;

   logic       done0, ov0, busy0;
   logic       done1, ov1, busy1;
   logic [7:0] res0, res1;

   int cyc = 0;
   int n_chk = 0;
   int n_err = 0;
   int acc0 = 0;
   int acc1 = 0;

   int exp_busy [MAXC];
   int exp_done [MAXC];
   int exp_r0   [MAXC];
   int exp_o0   [MAXC];
   int exp_r1   [MAXC];
   int exp_o1   [MAXC];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   param_alu #(.DATA_WIDTH(8), .SATURATE(0)) u_dut0 (
      .clk          (clk),
      .reset_n      (reset_n),
      .opcode_valid (opcode_valid),
      .opcode       (opcode),
      .data         (data),
      .done         (done0),
      .result       (res0),
      .overflow     (ov0),
      .busy         (busy0)
   );

   param_alu #(.DATA_WIDTH(8), .SATURATE(1)) u_dut1 (
      .clk          (clk),
      .reset_n      (reset_n),
      .opcode_valid (opcode_valid),
      .opcode       (opcode),
      .data         (data),
      .done         (done1),
      .result       (res1),
      .overflow     (ov1),
      .busy         (busy1)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
      end
   endtask

   // Reference arithmetic for 8-bit operands
   function automatic void alu_ref(input int op, input int a, input int b,
                                   input int sat, output int r, output int ov);
      int s;
      r  = 0;
      ov = 0;
      case (op)
         0: begin
            s  = a + b;
            ov = (s > 255) ? 1 : 0;
            r  = (ov != 0) ? ((sat != 0) ? 255 : s - 256) : s;
         end
         1: begin
            ov = (a < b) ? 1 : 0;
            r  = (ov != 0) ? ((sat != 0) ? 0 : a - b + 256) : a - b;
         end
         2: begin
            s  = a * b;
            ov = (s > 255) ? 1 : 0;
            r  = (ov != 0) ? ((sat != 0) ? 255 : s % 256) : s;
         end
         default: begin
            r  = 0;
            ov = 0;
         end
      endcase
   endfunction

   task automatic expect_cmd(input int op, input int a, input int b,
                             output int r0, output int o0, output int r1, output int o1);
      if (op == 3) begin
`ifdef PARAM_ALU_ACC_EN
         alu_ref(0, acc0, a, 0, r0, o0);
         acc0 = r0;
         alu_ref(0, acc1, a, 1, r1, o1);
         acc1 = r1;
`else
         r0 = 0; o0 = 0; r1 = 0; o1 = 0;
`endif
      end else begin
         alu_ref(op, a, b, 0, r0, o0);
         alu_ref(op, a, b, 1, r1, o1);
      end
   endtask

   // done pulses in cycle k; result/overflow hold from k onward
   task automatic sched(input int k, input int r0, input int o0, input int r1, input int o1);
      exp_done[k] = 1;
      for (int i = k; i < MAXC; i++) begin
         exp_r0[i] = r0; exp_o0[i] = o0;
         exp_r1[i] = r1; exp_o1[i] = o1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      opcode_valid = 1'b0;
      repeat (n) begin
         data   = 8'($urandom_range(255));
         opcode = 2'($urandom_range(3));
         step();
      end
   endtask

   // Reset (with opcode_valid high to show reset priority) for n edges
   task automatic do_reset(input int n);
      int r;
      r = cyc + 1;
      for (int i = r; i < MAXC; i++) begin
         exp_busy[i] = 0; exp_done[i] = 0;
         exp_r0[i] = 0; exp_o0[i] = 0;
         exp_r1[i] = 0; exp_o1[i] = 0;
      end
      acc0 = 0;
      acc1 = 0;
      reset_n      = 1'b0;
      opcode_valid = 1'b1;
      opcode       = 2'd0;
      data         = 8'd9;
      repeat (n) step();
      reset_n      = 1'b1;
      opcode_valid = 1'b0;
   endtask

   // Drive a command up to the edge that enters EXEC; noise pulses
   // opcode_valid on the OPB edge, where it must be ignored.
   task automatic issue(input int op, input int a, input int b, input bit noise);
      int n, r0, o0, r1, o1;
      n = cyc + 1;
      expect_cmd(op, a, b, r0, o0, r1, o1);
      exp_busy[n] = 1;
      if (op == 3) begin
         sched(n + 1, r0, o0, r1, o1);
      end else begin
         exp_busy[n + 1] = 1;
         sched(n + 2, r0, o0, r1, o1);
      end
      opcode_valid = 1'b1;
      opcode       = 2'(op);
      data         = 8'(a);
      step();
      if (op != 3) begin
         opcode_valid = noise;
         opcode       = 2'($urandom_range(3));
         data         = 8'(b);
         step();
      end
      opcode_valid = 1'b0;
   endtask

   // The EXEC edge; noise pulses opcode_valid there, which must be ignored
   task automatic fin(input bit noise);
      opcode_valid = noise;
      opcode       = 2'($urandom_range(3));
      data         = 8'($urandom_range(255));
      step();
      opcode_valid = 1'b0;
   endtask

   // Per-cycle comparison against the timeline
   always @(negedge clk) begin
      if (cyc >= 1 && cyc < MAXC) begin
         chk("done0",     int'(done0), exp_done[cyc]);
         chk("busy0",     int'(busy0), exp_busy[cyc]);
         chk("result0",   int'(res0),  exp_r0[cyc]);
         chk("overflow0", int'(ov0),   exp_o0[cyc]);
         chk("done1",     int'(done1), exp_done[cyc]);
         chk("busy1",     int'(busy1), exp_busy[cyc]);
         chk("result1",   int'(res1),  exp_r1[cyc]);
         chk("overflow1", int'(ov1),   exp_o1[cyc]);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      int r, o;
      for (int i = 0; i < MAXC; i++) begin
         exp_busy[i] = 0; exp_done[i] = 0;
         exp_r0[i] = 0; exp_o0[i] = 0;
         exp_r1[i] = 0; exp_o1[i] = 0;
      end
      reset_n      = 1'b0;
      opcode_valid = 1'b0;
      opcode       = 2'd0;
      data         = 8'd0;

      // Pin the reference model to hand-computed values
      alu_ref(0, 200, 100, 0, r, o); chk("pin_add_r", r, 44);  chk("pin_add_o", o, 1);
      alu_ref(0, 200, 100, 1, r, o); chk("pin_adds_r", r, 255); chk("pin_adds_o", o, 1);
      alu_ref(1, 5, 7, 0, r, o);     chk("pin_sub57_r", r, 254); chk("pin_sub57_o", o, 1);
      alu_ref(1, 7, 5, 0, r, o);     chk("pin_sub75_r", r, 2);   chk("pin_sub75_o", o, 0);
      alu_ref(2, 15, 17, 0, r, o);   chk("pin_mul1_r", r, 255);  chk("pin_mul1_o", o, 0);
      alu_ref(2, 16, 16, 0, r, o);   chk("pin_mul2_r", r, 0);    chk("pin_mul2_o", o, 1);
      alu_ref(1, 5, 7, 1, r, o);     chk("pin_subs_r", r, 0);    chk("pin_subs_o", o, 1);

      do_reset(2);
      idle(1);

      // ADD 200,100: done exactly two edges after the opcode_valid edge
      issue(0, 200, 100, 1'b0);
      fin(1'b0);
      chk("lit_add_done", int'(done0), 1);
      chk("lit_add_r0",   int'(res0),  44);
      chk("lit_add_o0",   int'(ov0),   1);
      chk("lit_add_r1",   int'(res1),  255);

      // Back-to-back commands accepted from DONE
      issue(1, 5, 7, 1'b0);    fin(1'b0);
      issue(1, 7, 5, 1'b0);    fin(1'b0);
      issue(2, 15, 17, 1'b0);  fin(1'b0);
      issue(2, 16, 16, 1'b0);  fin(1'b0);
      idle(3);

      // opcode_valid pulsed in OPB and EXEC is ignored
      issue(0, 3, 4, 1'b1);    fin(1'b1);
      chk("lit_noise_r0", int'(res0), 7);
      idle(2);

      // Boundary operands
      issue(0, 255, 255, 1'b0); fin(1'b0);
      issue(1, 0, 0, 1'b0);     fin(1'b0);
      issue(2, 255, 255, 1'b0); fin(1'b0);
      issue(0, 0, 0, 1'b0);     fin(1'b0);
      idle(2);

      // Accumulator after reset, back-to-back
      do_reset(1);
      issue(3, 100, 0, 1'b0);  fin(1'b0);
      chk("lit_acc1_done", int'(done0), 1);
      issue(3, 200, 0, 1'b0);  fin(1'b0);
`ifdef PARAM_ALU_ACC_EN
      chk("lit_acc2_r0", int'(res0), 44);
      chk("lit_acc2_o0", int'(ov0),  1);
      chk("lit_acc2_r1", int'(res1), 255);
`else
      chk("lit_acc2_r0", int'(res0), 0);
      chk("lit_acc2_o0", int'(ov0),  0);
`endif
      issue(3, 7, 0, 1'b0);    fin(1'b0);
      idle(2);

      // Reset sampled in EXEC aborts the command
      issue(2, 20, 30, 1'b0);
      do_reset(1);
      chk("lit_abort_done", int'(done0), 0);
      chk("lit_abort_r0",   int'(res0),  0);
      chk("lit_abort_busy", int'(busy0), 0);
      idle(2);

      // Reset sampled in OPB also aborts
      opcode_valid = 1'b1;
      opcode       = 2'd0;
      data         = 8'd50;
      begin
         int n;
         n = cyc + 1;
         exp_busy[n] = 1;
      end
      step();
      do_reset(1);
      idle(1);

      issue(0, 1, 2, 1'b0);    fin(1'b0);
      issue(3, 5, 0, 1'b0);    fin(1'b0);
      idle(4);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
